// File: rtl/enemy_motion.sv
// Per-enemy motion controller: chases the player one axis at a time, attacks on
// contact, is knocked back when shot and dies when its hit points run out.
module enemy_motion #(
    parameter logic [8:0] X_INIT       = 9'd40,
    parameter logic [8:0] Y_INIT       = 9'd40,
    parameter logic [8:0] X_MAX        = 9'd303,
    parameter logic [8:0] Y_MAX        = 9'd223,
    parameter logic [8:0] STEP         = 9'd1,
    parameter logic [8:0] KNOCK        = 9'd4,
    parameter logic [2:0] KNOCK_FRAMES = 3'd4,
    parameter logic [8:0] HIT_RANGE    = 9'd8,
    parameter logic [1:0] HP_INIT      = 2'd3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       Spawn,
    input  logic       Hit,
    input  logic [1:0] Hit_Dir,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    output logic [8:0] Obj_X_Pos,
    output logic [8:0] Obj_Y_Pos,
    output logic [8:0] Obj_X_Motion,
    output logic [8:0] Obj_Y_Motion,
    output logic [1:0] Obj_Dir,
    output logic       Alive,
    output logic       Attack
);

    typedef enum logic [1:0] {
        S_DEAD  = 2'd0,
        S_CHASE = 2'd1,
        S_KNOCK = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [8:0] NEG_STEP  = 9'd0 - STEP;
    localparam logic [8:0] NEG_KNOCK = 9'd0 - KNOCK;

    state_t     state_q, state_d;
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [8:0] x_motion_q, x_motion_d;
    logic [8:0] y_motion_q, y_motion_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] hp_q, hp_d;
    logic [2:0] kc_q, kc_d;
    logic [1:0] knock_dir_q, knock_dir_d;

    logic signed [9:0] dx, dy;
    logic [9:0]        abs_dx, abs_dy;
    logic              contact;
    logic              dx_pos, dy_pos;

    // Adds a signed motion to an unsigned position and saturates to [0, maxv].
    function automatic logic [8:0] clamp_add(input logic [8:0] pos,
                                             input logic [8:0] mot,
                                             input logic [8:0] maxv);
        logic signed [10:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{2{mot[8]}}, mot});
        if (sum[10])
            return 9'd0;
        else if (sum > $signed({2'b00, maxv}))
            return maxv;
        else
            return sum[8:0];
    endfunction

    always_comb begin
        dx      = $signed({1'b0, Player_X}) - $signed({1'b0, x_q});
        dy      = $signed({1'b0, Player_Y}) - $signed({1'b0, y_q});
        abs_dx  = dx[9] ? $unsigned(-dx) : $unsigned(dx);
        abs_dy  = dy[9] ? $unsigned(-dy) : $unsigned(dy);
        dx_pos  = !dx[9] && (dx != 10'sd0);
        dy_pos  = !dy[9] && (dy != 10'sd0);
        contact = (abs_dx <= {1'b0, HIT_RANGE}) && (abs_dy <= {1'b0, HIT_RANGE});
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        x_motion_d  = 9'd0;
        y_motion_d  = 9'd0;
        dir_d       = dir_q;
        hp_d        = hp_q;
        kc_d        = kc_q;
        knock_dir_d = knock_dir_q;

        case (state_q)
            S_DEAD: begin
                if (Spawn) begin
                    state_d = S_CHASE;
                    x_d     = X_INIT;
                    y_d     = Y_INIT;
                    hp_d    = HP_INIT;
                end
            end
            S_CHASE: begin
                if (Hit) begin
                    hp_d        = hp_q - 2'd1;
                    kc_d        = 3'd0;
                    knock_dir_d = Hit_Dir;
                    state_d     = (hp_q == 2'd1) ? S_DEAD : S_KNOCK;
                end else if (!contact) begin
                    // Ties go to the X axis.
                    if (abs_dx >= abs_dy) begin
                        x_motion_d = dx_pos ? STEP : NEG_STEP;
                        dir_d      = dx_pos ? DIR_RIGHT : DIR_LEFT;
                    end else begin
                        y_motion_d = dy_pos ? STEP : NEG_STEP;
                        dir_d      = dy_pos ? DIR_DOWN : DIR_UP;
                    end
                end
            end
            S_KNOCK: begin
                case (knock_dir_q)
                    DIR_UP:   y_motion_d = NEG_KNOCK;
                    DIR_DOWN: y_motion_d = KNOCK;
                    DIR_LEFT: x_motion_d = NEG_KNOCK;
                    default:  x_motion_d = KNOCK;
                endcase
                kc_d = kc_q + 3'd1;
                if (kc_q == KNOCK_FRAMES - 3'd1)
                    state_d = S_CHASE;
            end
            default: begin
                state_d = S_DEAD;
            end
        endcase

        // Zero motion leaves an in-range position untouched, so hold cases fall through here.
        if (state_q != S_DEAD) begin
            x_d = clamp_add(x_q, x_motion_d, X_MAX);
            y_d = clamp_add(y_q, y_motion_d, Y_MAX);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_DEAD;
            x_q         <= X_INIT;
            y_q         <= Y_INIT;
            x_motion_q  <= 9'd0;
            y_motion_q  <= 9'd0;
            dir_q       <= DIR_DOWN;
            hp_q        <= 2'd0;
            kc_q        <= 3'd0;
            knock_dir_q <= DIR_UP;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_motion_q  <= x_motion_d;
            y_motion_q  <= y_motion_d;
            dir_q       <= dir_d;
            hp_q        <= hp_d;
            kc_q        <= kc_d;
            knock_dir_q <= knock_dir_d;
        end
    end

    assign Obj_X_Pos    = x_q;
    assign Obj_Y_Pos    = y_q;
    assign Obj_X_Motion = x_motion_q;
    assign Obj_Y_Motion = y_motion_q;
    assign Obj_Dir      = dir_q;
    assign Alive        = (state_q != S_DEAD);
    assign Attack       = (state_q == S_CHASE) && contact;

endmodule

// File: tb/tb_enemy_motion.sv
// Bench for enemy_motion: a hand-derived vector table, a few directed corner
// sequences, then random frames checked against an integer reference model.
module tb_enemy_motion;

    logic       frame_clk;
    logic       Reset;
    logic       Spawn;
    logic       Hit;
    logic [1:0] Hit_Dir;
    logic [8:0] Player_X, Player_Y;
    logic [8:0] Obj_X_Pos, Obj_Y_Pos, Obj_X_Motion, Obj_Y_Motion;
    logic [1:0] Obj_Dir;
    logic       Alive, Attack;

    enemy_motion dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .Spawn       (Spawn),
        .Hit         (Hit),
        .Hit_Dir     (Hit_Dir),
        .Player_X    (Player_X),
        .Player_Y    (Player_Y),
        .Obj_X_Pos   (Obj_X_Pos),
        .Obj_Y_Pos   (Obj_Y_Pos),
        .Obj_X_Motion(Obj_X_Motion),
        .Obj_Y_Motion(Obj_Y_Motion),
        .Obj_Dir     (Obj_Dir),
        .Alive       (Alive),
        .Attack      (Attack)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integers, frames-remaining knock counter.
    localparam int M_DEAD = 0, M_CHASE = 1, M_KNOCK = 2;
    int m_state, m_x, m_y, m_xm, m_ym, m_dir, m_hp, m_left, m_kdir;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_state = M_DEAD; m_x = 40; m_y = 40; m_xm = 0; m_ym = 0;
        m_dir = 1; m_hp = 0; m_left = 0; m_kdir = 0;
    endtask

    task automatic model_edge(input int sp, input int ht, input int hd, input int px, input int py);
        int was_dead, ddx, ddy;
        was_dead = (m_state == M_DEAD);
        m_xm = 0;
        m_ym = 0;
        if (m_state == M_DEAD) begin
            if (sp != 0) begin
                m_state = M_CHASE; m_x = 40; m_y = 40; m_hp = 3;
            end
        end else if (m_state == M_CHASE) begin
            if (ht != 0) begin
                m_hp = m_hp - 1;
                if (m_hp == 0) m_state = M_DEAD;
                else begin m_state = M_KNOCK; m_left = 4; m_kdir = hd; end
            end else begin
                ddx = px - m_x;
                ddy = py - m_y;
                if (!(iabs(ddx) <= 8 && iabs(ddy) <= 8)) begin
                    if (iabs(ddx) >= iabs(ddy)) begin
                        m_xm = (ddx > 0) ? 1 : -1;
                        m_dir = (ddx > 0) ? 3 : 2;
                    end else begin
                        m_ym = (ddy > 0) ? 1 : -1;
                        m_dir = (ddy > 0) ? 1 : 0;
                    end
                end
            end
        end else begin
            case (m_kdir)
                0: m_ym = -4;
                1: m_ym = 4;
                2: m_xm = -4;
                default: m_xm = 4;
            endcase
            m_left = m_left - 1;
            if (m_left == 0) m_state = M_CHASE;
        end
        if (was_dead == 0) begin
            m_x = clampi(m_x + m_xm, 303);
            m_y = clampi(m_y + m_ym, 223);
        end
    endtask

    task automatic check_model(input string tag, input int px, input int py);
        int atk;
        atk = (m_state == M_CHASE && iabs(px - m_x) <= 8 && iabs(py - m_y) <= 8) ? 1 : 0;
        chk({tag, ".x"},     int'(Obj_X_Pos),    m_x);
        chk({tag, ".y"},     int'(Obj_Y_Pos),    m_y);
        chk({tag, ".xm"},    int'(Obj_X_Motion), m_xm & 'h1FF);
        chk({tag, ".ym"},    int'(Obj_Y_Motion), m_ym & 'h1FF);
        chk({tag, ".dir"},   int'(Obj_Dir),      m_dir);
        chk({tag, ".alive"}, int'(Alive),        (m_state != M_DEAD) ? 1 : 0);
        chk({tag, ".atk"},   int'(Attack),       atk);
    endtask

    // Called at posedge+1; drives inputs, takes one edge and checks against the model.
    task automatic do_cycle(input string tag, input logic sp, input logic ht, input logic [1:0] hd,
                            input logic [8:0] px, input logic [8:0] py);
        Spawn = sp; Hit = ht; Hit_Dir = hd; Player_X = px; Player_Y = py;
        @(posedge frame_clk);
        model_edge(int'(sp), int'(ht), int'(hd), int'(px), int'(py));
        #1;
        check_model(tag, int'(px), int'(py));
    endtask

    typedef struct {
        int sp, ht, hd, px, py;
        int x, y, xm, ym, dir, alive, atk;
    } vec_t;

    function automatic vec_t mk(input int sp, ht, hd, px, py, x, y, xm, ym, dir, alive, atk);
        vec_t v;
        v.sp = sp; v.ht = ht; v.hd = hd; v.px = px; v.py = py;
        v.x = x; v.y = y; v.xm = xm; v.ym = ym; v.dir = dir; v.alive = alive; v.atk = atk;
        return v;
    endfunction

    vec_t vecs[21];

    initial begin
        logic       r_sp, r_ht;
        logic [1:0] r_hd;
        logic [8:0] r_px, r_py;

        vecs[0]  = mk(0,0,0,100,50, 40,40,0,0,1,0,0);
        vecs[1]  = mk(1,0,0,100,50, 40,40,0,0,1,1,0);
        vecs[2]  = mk(0,0,0,100,50, 41,40,1,0,3,1,0);
        vecs[3]  = mk(0,0,0,40,0,   41,39,0,'h1FF,0,1,0);
        vecs[4]  = mk(0,0,0,51,49,  42,39,1,0,3,1,0);
        vecs[5]  = mk(0,0,0,50,31,  42,39,0,0,3,1,1);
        vecs[6]  = mk(0,0,0,51,39,  43,39,1,0,3,1,1);
        vecs[7]  = mk(0,1,3,51,39,  43,39,0,0,3,1,0);
        vecs[8]  = mk(0,0,0,51,39,  47,39,4,0,3,1,0);
        vecs[9]  = mk(1,1,0,51,39,  51,39,4,0,3,1,0);
        vecs[10] = mk(0,0,0,51,39,  55,39,4,0,3,1,0);
        vecs[11] = mk(0,0,0,51,39,  59,39,4,0,3,1,1);
        vecs[12] = mk(0,0,0,51,39,  59,39,0,0,3,1,1);
        vecs[13] = mk(0,1,0,51,39,  59,39,0,0,3,1,0);
        vecs[14] = mk(0,0,0,51,39,  59,35,0,'h1FC,3,1,0);
        vecs[15] = mk(0,0,0,51,39,  59,31,0,'h1FC,3,1,0);
        vecs[16] = mk(0,0,0,51,39,  59,27,0,'h1FC,3,1,0);
        vecs[17] = mk(0,0,0,51,39,  59,23,0,'h1FC,3,1,0);
        vecs[18] = mk(0,1,0,51,39,  59,23,0,0,3,0,0);
        vecs[19] = mk(1,1,0,51,39,  40,40,0,0,3,1,0);
        vecs[20] = mk(0,0,0,51,39,  41,40,1,0,3,1,0);

        Reset = 1'b1; Spawn = 1'b0; Hit = 1'b0; Hit_Dir = 2'b00;
        Player_X = 9'd40; Player_Y = 9'd40;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        Reset = 1'b0;

        // Dead after reset, player on top of the enemy: no attack while dead.
        for (int i = 0; i < 5; i++) begin
            do_cycle($sformatf("idle%0d", i), 1'b0, 1'b0, 2'b00, 9'd40, 9'd40);
            chk($sformatf("idle%0d.xc", i), int'(Obj_X_Pos), 40);
            chk($sformatf("idle%0d.dirc", i), int'(Obj_Dir), 1);
        end

        for (int i = 0; i < 21; i++) begin
            Spawn = vecs[i].sp[0]; Hit = vecs[i].ht[0]; Hit_Dir = vecs[i].hd[1:0];
            Player_X = vecs[i].px[8:0]; Player_Y = vecs[i].py[8:0];
            @(posedge frame_clk);
            model_edge(vecs[i].sp, vecs[i].ht, vecs[i].hd, vecs[i].px, vecs[i].py);
            #1;
            chk($sformatf("vec%0d.x", i),     int'(Obj_X_Pos),    vecs[i].x);
            chk($sformatf("vec%0d.y", i),     int'(Obj_Y_Pos),    vecs[i].y);
            chk($sformatf("vec%0d.xm", i),    int'(Obj_X_Motion), vecs[i].xm);
            chk($sformatf("vec%0d.ym", i),    int'(Obj_Y_Motion), vecs[i].ym);
            chk($sformatf("vec%0d.dir", i),   int'(Obj_Dir),      vecs[i].dir);
            chk($sformatf("vec%0d.alive", i), int'(Alive),        vecs[i].alive);
            chk($sformatf("vec%0d.atk", i),   int'(Attack),       vecs[i].atk);
        end

        // Walk left to contact, then knock left into the X=0 wall twice.
        for (int i = 0; i < 40; i++)
            do_cycle($sformatf("walk%0d", i), 1'b0, 1'b0, 2'b00, 9'd0, 9'd40);
        chk("walk.x_at_contact", int'(Obj_X_Pos), 8);
        do_cycle("hitA", 1'b0, 1'b1, 2'b10, 9'd0, 9'd40);
        chk("hitA.x_held", int'(Obj_X_Pos), 8);
        for (int i = 0; i < 4; i++)
            do_cycle($sformatf("knockA%0d", i), 1'b0, 1'b0, 2'b00, 9'd0, 9'd40);
        chk("knockA.x_clamped", int'(Obj_X_Pos), 0);
        chk("knockA.xm_req", int'(Obj_X_Motion), 'h1FC);
        do_cycle("hitB", 1'b0, 1'b1, 2'b10, 9'd0, 9'd40);
        for (int i = 0; i < 4; i++) begin
            do_cycle($sformatf("knockB%0d", i), 1'b0, 1'b1, 2'b01, 9'd0, 9'd100);
            chk($sformatf("knockB%0d.x0", i), int'(Obj_X_Pos), 0);
            chk($sformatf("knockB%0d.xm", i), int'(Obj_X_Motion), 'h1FC);
        end
        do_cycle("resume", 1'b0, 1'b0, 2'b00, 9'd0, 9'd100);
        chk("resume.ym", int'(Obj_Y_Motion), 1);
        chk("resume.y", int'(Obj_Y_Pos), 41);
        do_cycle("hitC", 1'b0, 1'b1, 2'b11, 9'd0, 9'd100);
        chk("hitC.dead", int'(Alive), 0);
        do_cycle("respawn", 1'b1, 1'b0, 2'b00, 9'd200, 9'd200);
        chk("respawn.x", int'(Obj_X_Pos), 40);
        chk("respawn.alive", int'(Alive), 1);

        // Reset in the middle of a knockback, between clock edges.
        do_cycle("hitD", 1'b0, 1'b1, 2'b11, 9'd200, 9'd200);
        do_cycle("knockD0", 1'b0, 1'b0, 2'b00, 9'd200, 9'd200);
        do_cycle("knockD1", 1'b0, 1'b0, 2'b00, 9'd200, 9'd200);
        Player_X = 9'd40; Player_Y = 9'd40;
        #2;
        Reset = 1'b1;
        #1;
        chk("areset.x", int'(Obj_X_Pos), 40);
        chk("areset.y", int'(Obj_Y_Pos), 40);
        chk("areset.xm", int'(Obj_X_Motion), 0);
        chk("areset.dir", int'(Obj_Dir), 1);
        chk("areset.alive", int'(Alive), 0);
        chk("areset.atk", int'(Attack), 0);
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++)
            do_cycle($sformatf("postrst%0d", i), 1'b0, 1'b1, 2'b00, 9'd40, 9'd40);

        // Random frames against the model.
        r_px = 9'd100; r_py = 9'd100;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                r_px = 9'($urandom_range(0, 511));
                r_py = 9'($urandom_range(0, 511));
            end
            r_sp = ($urandom_range(0, 7) == 0);
            r_ht = ($urandom_range(0, 11) == 0);
            r_hd = 2'($urandom_range(0, 3));
            do_cycle($sformatf("rnd%0d", i), r_sp, r_ht, r_hd, r_px, r_py);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
